// File: rtl/mio_bus.sv
`default_nettype none
// ============================================================================
//  Module   : mio_bus
//  Purpose  : Memory/IO bus controller behind the multi-cycle CPU MIO port.
//             Serves one request at a time. Decodes the address to block RAM,
//             the LED/switch port, the 7-segment register or a free-running
//             counter, and returns a one-cycle mio_ready completion pulse.
//  Ports    : clk, reset              - clock, synchronous active-high reset
//             cpu_mio, mem_w          - request valid, write(1)/read(0)
//             addr_bus, cpu_data_out  - byte address and write data from CPU
//             cpu_data_in, mio_ready  - registered read data, done pulse
//             ram_addr, ram_data_in,
//             ram_we, ram_data_out    - block RAM port (word addressed)
//             switches, gpio_led      - board switches, LED register
//             seg7_data               - 7-segment display register
//  Revision : 1.0 - initial release
// ============================================================================
module mio_bus #(
  parameter int RAM_WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mio,
  input  logic        mem_w,
  input  logic [31:0] addr_bus,
  input  logic [31:0] cpu_data_out,
  output logic [31:0] cpu_data_in,
  output logic        mio_ready,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_data_in,
  output logic        ram_we,
  input  logic [31:0] ram_data_out,
  input  logic [15:0] switches,
  output logic [15:0] gpio_led,
  output logic [31:0] seg7_data
);

  localparam logic [31:0] C_SEG7_ADDR = 32'hE000_0000;
  localparam logic [31:0] C_GPIO_ADDR = 32'hF000_0000;
  localparam logic [31:0] C_CNT_ADDR  = 32'hF000_0004;

  localparam int WCNT_W = (RAM_WAIT_CYC > 1) ? $clog2(RAM_WAIT_CYC) : 1;
  localparam logic [WCNT_W-1:0] C_WCNT_LAST = WCNT_W'(RAM_WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RAM_WAIT = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [9:0]        r_word;
  logic [31:0]       r_wdata;
  logic              r_wr;
  logic [31:0]       r_counter;

  logic              w_is_ram;
  logic              w_is_seg7;
  logic              w_is_gpio;
  logic              w_is_cnt;
  logic              w_capture;
  logic              w_wait_last;
  logic [31:0]       w_io_rdata;

  // Decode works on the live bus: it only matters in the capture cycle.
  assign w_is_ram    = (addr_bus[31:12] == 20'd0);
  assign w_is_seg7   = (addr_bus == C_SEG7_ADDR);
  assign w_is_gpio   = (addr_bus == C_GPIO_ADDR);
  assign w_is_cnt    = (addr_bus == C_CNT_ADDR);
  assign w_capture   = (r_state == S_IDLE) && cpu_mio;
  assign w_wait_last = (r_wcnt == C_WCNT_LAST);

  // RAM port comes straight from the captured request; the write strobe is
  // confined to the first wait cycle so a write lands exactly once.
  assign ram_addr    = r_word;
  assign ram_data_in = r_wdata;
  assign ram_we      = (r_state == S_RAM_WAIT) && (r_wcnt == '0) && r_wr;

  // IO read mux; unmapped addresses read as zero.
  always_comb begin
    w_io_rdata = '0;
    if (w_is_seg7) begin
      w_io_rdata = seg7_data;
    end else if (w_is_gpio) begin
      w_io_rdata = {16'h0000, switches};
    end else if (w_is_cnt) begin
      w_io_rdata = r_counter;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_mio) begin
          w_next_state = w_is_ram ? S_RAM_WAIT : S_DONE;
        end
      end
      S_RAM_WAIT: begin
        if (w_wait_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt      <= '0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_counter   <= '0;
      cpu_data_in <= '0;
      mio_ready   <= 1'b0;
      gpio_led    <= '0;
      seg7_data   <= '0;
    end else begin
      // Pulse is high exactly while the FSM sits in DONE.
      mio_ready <= (w_next_state == S_DONE);
      // Free-running count; a counter write below overrides it on that edge.
      r_counter <= r_counter + 32'd1;

      case (r_state)
        S_IDLE: begin
          r_wcnt <= '0;
          if (w_capture) begin
            r_word  <= addr_bus[11:2];
            r_wdata <= cpu_data_out;
            r_wr    <= mem_w;
            if (!w_is_ram) begin
              if (mem_w) begin
                if (w_is_seg7) seg7_data <= cpu_data_out;
                if (w_is_gpio) gpio_led  <= cpu_data_out[15:0];
                if (w_is_cnt)  r_counter <= cpu_data_out;
              end else begin
                cpu_data_in <= w_io_rdata;
              end
            end
          end
        end
        S_RAM_WAIT: begin
          r_wcnt <= r_wcnt + WCNT_W'(1);
          if (w_wait_last && !r_wr) begin
            cpu_data_in <= ram_data_out;
          end
        end
        default: begin
          r_wcnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mio_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mio_bus
//  Purpose  : Self-checking bench for mio_bus. Provides a synchronous block
//             RAM, drives directed and random CPU requests, and compares the
//             results against an address-map level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mio_bus;

  localparam int RWC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mio;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic [31:0] cpu_data_out;
  logic [31:0] cpu_data_in;
  logic        mio_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic        ram_we;
  logic [31:0] ram_data_out;
  logic [15:0] switches;
  logic [15:0] gpio_led;
  logic [31:0] seg7_data;

  always #5 clk = ~clk;

  mio_bus #(.RAM_WAIT_CYC(RWC)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_mio      (cpu_mio),
    .mem_w        (mem_w),
    .addr_bus     (addr_bus),
    .cpu_data_out (cpu_data_out),
    .cpu_data_in  (cpu_data_in),
    .mio_ready    (mio_ready),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out),
    .switches     (switches),
    .gpio_led     (gpio_led),
    .seg7_data    (seg7_data)
  );

  // Unwritten RAM words hold a fixed per-word pattern.
  function automatic logic [31:0] fill(input logic [9:0] w);
    return 32'hC0DE_0000 + (32'(w) * 32'h0001_0101);
  endfunction

  // Synchronous block RAM, one cycle read latency.
  logic [31:0] ram_mem [1024];
  bit          ram_vld [1024];
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      ram_mem[ram_addr] <= ram_data_in;
      ram_vld[ram_addr] <= 1'b1;
    end
    ram_data_out <= ram_vld[ram_addr] ? ram_mem[ram_addr] : fill(ram_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          we_cnt    = 0;
  int          ready_cnt = 0;
  logic [9:0]  we_addr   = '0;
  logic [31:0] we_data   = '0;
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
      we_data <= ram_data_in;
    end
    if (mio_ready === 1'b1) ready_cnt <= ready_cnt + 1;
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] m_seg7;
  logic [15:0] m_led;
  logic [31:0] m_din;
  logic [31:0] cnt_base;
  int          cnt_base_cyc;

  int compared   = 0;
  int mismatched = 0;
  int n_txn      = 0;
  bit started    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU request. chain: cpu_mio already high from the previous request.
  // keep: leave cpu_mio high after completion for a back-to-back request.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit chain, input bit keep);
    int          we0;
    int          lat;
    int          cap;
    int          w;
    logic [31:0] exp_rd;
    string       t;
    bit          ram;
    n_txn++;
    t   = $sformatf("t%0d", n_txn);
    ram = (a[31:12] == 20'd0);
    w   = int'(a[11:2]);
    if (!chain) begin
      @(negedge clk);
      #1;
      if (started) check({t, "_ready_gap"}, 32'(mio_ready), 32'd0);
    end
    started      = 1'b1;
    we0          = we_cnt;
    cpu_mio      = 1'b1;
    mem_w        = wr;
    addr_bus     = a;
    cpu_data_out = d;
    if (chain) @(posedge clk);
    @(posedge clk);
    #1;
    cap = cyc;

    exp_rd = 32'd0;
    if (ram)                    exp_rd = ref_mem.exists(w) ? ref_mem[w] : fill(a[11:2]);
    else if (a == 32'hE000_0000) exp_rd = m_seg7;
    else if (a == 32'hF000_0000) exp_rd = {16'h0000, switches};
    else if (a == 32'hF000_0004) exp_rd = cnt_base + 32'(cap - 1 - cnt_base_cyc);
    if (wr) begin
      if (ram)                    ref_mem[w] = d;
      else if (a == 32'hE000_0000) m_seg7 = d;
      else if (a == 32'hF000_0000) m_led = d[15:0];
      else if (a == 32'hF000_0004) begin cnt_base = d; cnt_base_cyc = cap; end
    end else begin
      m_din = exp_rd;
    end

    if (!ram) begin
      check({t, "_led_at_capture"}, 32'(gpio_led), 32'(m_led));
      check({t, "_seg7_at_capture"}, seg7_data, m_seg7);
    end

    // Bus contents after capture must not matter.
    mem_w        = 1'($urandom);
    addr_bus     = $urandom;
    cpu_data_out = $urandom;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (mio_ready !== 1'b1 && lat < 20);
    #1;
    if (!keep) cpu_mio = 1'b0;

    check({t, "_latency"}, 32'(lat), ram ? 32'(RWC + 1) : 32'd1);
    check({t, "_cpu_data_in"}, cpu_data_in, m_din);
    check({t, "_we_pulses"}, 32'(we_cnt - we0), (ram && wr) ? 32'd1 : 32'd0);
    if (ram && wr) begin
      check({t, "_we_addr"}, 32'(we_addr), 32'(a[11:2]));
      check({t, "_we_data"}, we_data, d);
    end
    check({t, "_gpio_led"}, 32'(gpio_led), 32'(m_led));
    check({t, "_seg7"}, seg7_data, m_seg7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          prev_keep;
    bit          keep;
    bit          wr;
    int          kind;
    logic [31:0] a;

    reset        = 1'b1;
    cpu_mio      = 1'b0;
    mem_w        = 1'b0;
    addr_bus     = '0;
    cpu_data_out = '0;
    switches     = 16'h0000;
    m_seg7       = '0;
    m_led        = '0;
    m_din        = '0;
    cnt_base     = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_data_in", cpu_data_in, 32'd0);
    check("rst_mio_ready", 32'(mio_ready), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_data_in", ram_data_in, 32'd0);
    check("rst_gpio_led", 32'(gpio_led), 32'd0);
    check("rst_seg7", seg7_data, 32'd0);
    reset        = 1'b0;
    cnt_base_cyc = cyc;

    // LED write
    txn(1'b1, 32'hF000_0000, 32'h0000_A5A5, 1'b0, 1'b0);
    check("led_a5a5", 32'(gpio_led), 32'h0000_A5A5);

    // RAM write then read of the same word
    txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
    check("ram_readback", cpu_data_in, 32'hDEAD_BEEF);

    // Counter load, immediate readback, then readback after wrapping
    txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1'b0, 1'b0);
    txn(1'b0, 32'hF000_0004, 32'h0, 1'b0, 1'b0);
    check("cnt_first_read", cpu_data_in, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    txn(1'b0, 32'hF000_0004, 32'h0, 1'b0, 1'b0);

    // 7-segment register
    txn(1'b1, 32'hE000_0000, 32'h1357_9BDF, 1'b0, 1'b0);
    txn(1'b0, 32'hE000_0000, 32'h0, 1'b0, 1'b0);

    // Unmapped read and write
    txn(1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    txn(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Back-to-back RAM reads with cpu_mio held high
    txn(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1);
    txn(1'b0, 32'h0000_0100, 32'h0, 1'b1, 1'b0);
    check("b2b_second_word", cpu_data_in, 32'h0BAD_F00D);

    // Reset during the second RAM_WAIT cycle of a read
    @(negedge clk);
    #1;
    cpu_mio  = 1'b1;
    mem_w    = 1'b0;
    addr_bus = 32'h0000_0020;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    cpu_mio = 1'b0;
    @(negedge clk);
    #1;
    reset        = 1'b0;
    cnt_base     = '0;
    cnt_base_cyc = cyc;
    m_led        = '0;
    m_seg7       = '0;
    m_din        = '0;
    check("rst_mid_ready", 32'(mio_ready), 32'd0);
    check("rst_mid_din", cpu_data_in, 32'd0);
    check("rst_mid_led", 32'(gpio_led), 32'd0);
    check("rst_mid_seg7", seg7_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_mid_no_ready", 32'(mio_ready), 32'd0);
    end
    switches = 16'h00FF;
    txn(1'b0, 32'hF000_0000, 32'h0, 1'b0, 1'b0);
    check("switch_read", cpu_data_in, 32'h0000_00FF);

    // Random traffic, with random back-to-back chaining
    prev_keep = 1'b0;
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 6));
      wr   = 1'($urandom);
      case (kind)
        0, 1:    a = {20'd0, 6'd0, 4'($urandom), 2'($urandom)};
        2:       a = {20'd0, 10'($urandom), 2'($urandom)};
        3:       a = 32'hE000_0000;
        4:       a = 32'hF000_0000;
        5:       a = 32'hF000_0004;
        default: a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
      endcase
      if (!prev_keep) switches = 16'($urandom);
      keep = (i < 59) && ($urandom_range(0, 2) == 0);
      txn(wr, a, $urandom, prev_keep, keep);
      prev_keep = keep;
    end

    repeat (3) @(negedge clk);
    #1;
    check("ready_total", 32'(ready_cnt), 32'(n_txn));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
